// File: rtl/period_meter_if.sv
// period_meter_if: result-side bus of period_meter.
//   master (meter):    drives period/valid/missed/ovf/stable, samples ready
//   slave  (consumer): drives ready, samples the rest
// DIV_BITS must match the period_meter instance it is bound to.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

interface period_meter_if #(
    parameter int DIV_BITS = `BYTE_BITS
);
    logic                ready;
    logic [DIV_BITS-1:0] period;
    logic                valid;
    logic                missed;
    logic                ovf;
    logic                stable;

    modport master (input ready, output period, valid, missed, ovf, stable);
    modport slave  (output ready, input period, valid, missed, ovf, stable);
endinterface

// File: rtl/period_meter.sv
// period_meter: measures spacing of an enable-pulse stream in enabled cycles.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   en     - measurement enable; when low the counter and state freeze
//   pulse  - pulse stream; each enabled high cycle is one event
//   res    - result bus (period/valid/missed/ovf/stable out, ready in)
// All outputs are registered.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module period_meter #(
    parameter int DIV_BITS = `BYTE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 pulse,
    period_meter_if.master       res
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [DIV_BITS-1:0] CNT_MAX = '1;

    state_t              state;
    logic [DIV_BITS-1:0] cnt;
    // A result exists since the last IDLE; gates the stable comparison.
    logic                have_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            have_prev  <= 1'b0;
            res.period <= '0;
            res.valid  <= 1'b0;
            res.missed <= 1'b0;
            res.ovf    <= 1'b0;
            res.stable <= 1'b0;
        end else begin
            res.missed <= 1'b0;
            // Consumption; a new result below overrides this clear.
            if (res.valid && res.ready)
                res.valid <= 1'b0;

            if (en) begin
                case (state)
                    IDLE: begin
                        if (pulse) begin
                            cnt     <= DIV_BITS'(1);
                            state   <= MEASURE;
                            res.ovf <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (pulse) begin
                            res.period <= cnt;
                            res.valid  <= 1'b1;
                            res.missed <= res.valid && !res.ready;
                            // period still holds the previous result here.
                            res.stable <= have_prev && (cnt == res.period);
                            have_prev  <= 1'b1;
                            cnt        <= DIV_BITS'(1);
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + DIV_BITS'(1);
                        end else begin
                            // Saturated with no pulse: drop the reference.
                            state      <= IDLE;
                            cnt        <= '0;
                            have_prev  <= 1'b0;
                            res.ovf    <= 1'b1;
                            res.stable <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;
    localparam int DIV_BITS = 8;
    localparam int MAXP     = (1 << DIV_BITS) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic pulse = 1'b0;

    always #5 clk = ~clk;

    period_meter_if #(.DIV_BITS(DIV_BITS)) bus ();

    period_meter #(.DIV_BITS(DIV_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .pulse (pulse),
        .res   (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events are numbered by enabled-cycle index; a result
    // is the index difference between consecutive events. The reference is
    // lost once MAXP enabled cycles pass without an event.
    typedef struct packed {
        bit live;
        int idx;
        int ref_idx;
        bit have_ref;
        int nres;
        int last;
        int period;
        bit valid;
        bit missed;
        bit ovf;
        bit stable;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_next(mstate_t s, logic r, logic e, logic p, logic rd);
        mstate_t n = s;
        int d;
        n.live = 1'b1;
        if (r) begin
            n = '0;
            n.live = 1'b1;
            return n;
        end
        n.missed = 1'b0;
        if (s.valid && rd) n.valid = 1'b0;
        if (e) begin
            n.idx = s.idx + 1;
            if (p) begin
                if (s.have_ref) begin
                    d        = n.idx - s.ref_idx;
                    n.missed = s.valid && !rd;
                    n.stable = (s.nres > 0) && (d == s.last);
                    n.period = d;
                    n.valid  = 1'b1;
                    n.last   = d;
                    n.nres   = s.nres + 1;
                end else begin
                    n.ovf = 1'b0;
                end
                n.ref_idx  = n.idx;
                n.have_ref = 1'b1;
            end else if (s.have_ref && (n.idx - s.ref_idx >= MAXP)) begin
                n.have_ref = 1'b0;
                n.ovf      = 1'b1;
                n.stable   = 1'b0;
                n.nres     = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, reset, en, pulse, bus.ready);

    // Single compare process: every output, every cycle, away from posedge.
    always @(negedge clk) begin
        if (m.live) begin
            chk("period", int'(bus.period), m.period);
            chk("valid",  int'(bus.valid),  int'(m.valid));
            chk("missed", int'(bus.missed), int'(m.missed));
            chk("ovf",    int'(bus.ovf),    int'(m.ovf));
            chk("stable", int'(bus.stable), int'(m.stable));
        end
    end

    // Apply inputs just after a negedge; return at the next negedge so the
    // outputs reflect the posedge that sampled these inputs.
    task automatic drive(input logic r, input logic e, input logic p, input logic rd);
        reset     = r;
        en        = e;
        pulse     = p;
        bus.ready = rd;
        @(negedge clk);
    endtask

    int cnt1;

    initial begin
        bus.ready = 1'b1;
        @(negedge clk);
        repeat (3) drive(1, 0, 0, 1);
        chk("rst_period", int'(bus.period), 0);
        chk("rst_valid",  int'(bus.valid),  0);
        chk("rst_missed", int'(bus.missed), 0);
        chk("rst_ovf",    int'(bus.ovf),    0);
        chk("rst_stable", int'(bus.stable), 0);

        // Pulse every 3rd cycle.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, (i % 3) == 0, 1);
            if (i == 0) chk("p3_first_noresult", int'(bus.valid), 0);
            if (i == 3) begin
                chk("p3_period", int'(bus.period), 3);
                chk("p3_valid",  int'(bus.valid),  1);
                chk("p3_stable0", int'(bus.stable), 0);
            end
            if (i == 4) chk("p3_valid_1cyc", int'(bus.valid), 0);
            if (i == 6) chk("p3_stable1", int'(bus.stable), 1);
        end

        // Pulse held high for 5 cycles from IDLE.
        drive(1, 0, 0, 1);
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, i < 5, 1);
            if (bus.valid && bus.period == 1) cnt1++;
        end
        chk("held_results", cnt1, 4);

        // Pulse every 4 enabled cycles with en low 3 cycles inside.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 1);
            repeat (3) drive(0, 0, 1, 1);
            repeat (3) drive(0, 1, 0, 1);
        end
        drive(0, 1, 1, 1);
        chk("engap_period", int'(bus.period), 4);
        chk("engap_stable", int'(bus.stable), 1);

        // Overflow.
        drive(0, 1, 1, 1);
        repeat (254) drive(0, 1, 0, 1);
        chk("ovf_pre", int'(bus.ovf), 0);
        drive(0, 1, 0, 1);
        chk("ovf_set", int'(bus.ovf), 1);
        chk("ovf_stable", int'(bus.stable), 0);
        drive(0, 1, 1, 1);
        chk("ovf_clear", int'(bus.ovf), 0);
        chk("ovf_noresult", int'(bus.valid), 0);
        repeat (6) drive(0, 1, 0, 1);
        drive(0, 1, 1, 1);
        chk("ovf_after_period", int'(bus.period), 7);
        chk("ovf_after_valid", int'(bus.valid), 1);

        // ready low, pulses every 2 cycles.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, (i % 2) == 0, 0);
            if (i == 2) begin
                chk("nrdy_period", int'(bus.period), 2);
                chk("nrdy_missed", int'(bus.missed), 1);
            end
            if (i == 3) begin
                chk("nrdy_missed_1cyc", int'(bus.missed), 0);
                chk("nrdy_valid", int'(bus.valid), 1);
            end
        end
        drive(0, 1, 0, 1);
        chk("nrdy_consume", int'(bus.valid), 0);

        // Reset mid-interval with a pending result.
        drive(0, 1, 1, 0);
        chk("mid_valid", int'(bus.valid), 1);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("mid_rst_valid",  int'(bus.valid),  0);
        chk("mid_rst_period", int'(bus.period), 0);
        chk("mid_rst_stable", int'(bus.stable), 0);
        drive(0, 1, 1, 1);
        chk("mid_first_noresult", int'(bus.valid), 0);
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 1);
        chk("mid_period", int'(bus.period), 2);

        // Random: dense pulses.
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
        // Random: sparse pulses to reach overflow and near-max periods.
        for (int i = 0; i < 4000; i++)
            drive(1'b0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/period_meter.md
# period_meter

Measures the spacing of an enable-pulse stream such as the one a frequency divider produces. It reports the measured divide ratio as a count of enabled clock cycles between consecutive pulses. It sits downstream of pulse generators in the motion path, where it is used for step-rate verification and closed-loop rate checks. Results are delivered over a valid/ready handshake, with overflow, missed-result and stability flags.

## Interface
Parameters:
- DIV_BITS, default `BYTE_BITS: width of the counter and of the period result.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enables measurement. When low, the counter freezes and pulses are ignored.
- pulse  in  1  pulse stream, sampled at posedge clk.
- ready  in  1  the consumer accepts the current result.
- period  out  DIV_BITS  last measured period, in enabled cycles.
- valid  out  1  period holds an unconsumed result.
- missed  out  1  one-cycle strobe: an unconsumed result was overwritten.
- ovf  out  1  counter saturated with no pulse; sticky until the next event.
- stable  out  1  the two most recent results are equal.

## Operation
- Event: a posedge where en=1 and pulse=1. Consecutive high cycles each count as separate events.
- Non-event enabled cycle: a posedge where en=1 and pulse=0.
- States:
  - IDLE: no reference pulse yet. Entered on reset and on overflow.
  - MEASURE: counting since the last event.
- IDLE:
  - On an event: counter<=1, go to MEASURE, ovf<=0. No result is produced.
  - Otherwise hold.
- MEASURE, on an event:
  - period<=counter, valid<=1, counter<=1.
  - stable<=(counter==previous result) and a previous result exists since IDLE.
  - Stay in MEASURE.
- MEASURE, on a non-event enabled cycle:
  - If counter < 2^DIV_BITS-1: counter<=counter+1.
  - Else (overflow): go to IDLE, ovf<=1, stable<=0, counter<=0. valid and period are untouched.
- en=0: counter and state hold; no events are recognised.
- Arithmetic: the counter is unsigned DIV_BITS wide and never wraps. The largest measurable period is 2^DIV_BITS-1 (255 at the default width).
- Handshake:
  - valid is cleared on a cycle where valid=1 and ready=1, unless a new result is loaded in the same cycle; then valid stays 1 with the new period.
  - New result while valid=1 and ready=0: period is overwritten, valid stays 1, missed=1 for that one cycle.
  - ready while valid=0 has no effect.
- Reset mid-operation discards the counter, any pending result and all flags.

## Timing
- All outputs are registered.
- Reset values: period=0, valid=0, missed=0, ovf=0, stable=0, state IDLE, counter=0.
- Latency: for an event at edge k, period, valid and stable update at edge k (visible the cycle after), so valid rises 1 cycle after the event cycle.
- A result is consumed at the edge where valid&ready.
- missed is asserted for exactly one cycle, coincident with the overwriting result.
- ovf rises at the edge of the (2^DIV_BITS-1)th consecutive non-event enabled cycle after a counter value of 1. It falls at the edge of the next event.
- Period definition: events at enabled-cycle indices j and k (consecutive, counting only en=1 cycles) give period = k-j.
  - A pulse held continuously high gives 1.
  - A pulse every N enabled cycles gives N.

## Test plan
- Pulse every 3rd cycle with en=1 and ready=1. Required: the first event gives no result; each later event gives period=3 with valid high for 1 cycle; stable=1 from the second result on.
- Pulse held high for 5 cycles from IDLE. Required: 4 results, each period=1.
- Pulse every 4 enabled cycles, with en held low for 3 cycles inside each interval. Required: period=4; the counter holds while en=0.
- One event, then 255 enabled cycles with no pulse. Required: ovf=1 at the 255th edge, state IDLE, stable=0. The next event clears ovf and produces no result; the event after it gives a correct period.
- ready=0 while pulses arrive every 2 cycles. Required: period updates to each new value, valid stays 1, missed pulses once per overwrite. ready=1 with no new event clears valid on the next edge.
- reset asserted mid-interval with valid=1. Required: all outputs return to 0. The next event produces no result.
